// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for an 8-digit common-anode 7-segment
// display. A load strobe captures a 32-bit hex word plus decimal points into
// a pending register. The displayed copy (shadow) is updated only at frame
// boundaries, so a frame never shows a mix of old and new values. Digits are
// scanned with a one-cycle blanking gap at the start of each dwell to suppress
// ghosting.
// Optional feature: define SEG7_LZ_BLANK_EN to blank leading zero digits.
module seg7_scan #(
   parameter int unsigned DIV        = 100000,
   parameter int unsigned NUM_DIGITS = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] data,
   input  logic [7:0]  dp,
   input  logic [7:0]  blank,
   output logic [7:0]  an,
   output logic [7:0]  seg,
   output logic        frame_done
);

   localparam int unsigned   CW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [2:0]    IDX_LAST = 3'(NUM_DIGITS - 1);

   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [39:0]   pend;
   logic [39:0]   shadow;

   logic          dwell_end;
   logic          frame_end;
   logic [7:0]    dark;
   logic [7:0]    shadow_dp;
   logic [3:0]    nib;
   logic          active;
   logic [7:0]    an_next;
   logic [7:0]    seg_next;

   // Hex nibble to active-low segments a..g (bit0..bit6)
   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h18;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Dwell and frame boundary detection
   always_comb begin
      dwell_end = (cnt == CNT_LAST);
      frame_end = dwell_end && (idx == IDX_LAST);
   end

`ifdef SEG7_LZ_BLANK_EN
   logic [7:0] lz;
   logic       all_zero;

   // Leading-zero mask: scan from the top digit down; digit 0 is never blanked
   always_comb begin
      lz       = '0;
      all_zero = 1'b1;
      for (int unsigned j = 0; j < 8; j++) begin
         if ((7 - j) < NUM_DIGITS) begin
            all_zero = all_zero & (shadow[4*(7-j) +: 4] == 4'h0);
            if (j != 7) lz[7-j] = all_zero;
         end
      end
      dark = blank | lz;
   end
`else
   // Only the live blank mask darkens digits
   always_comb begin
      dark = blank;
   end
`endif

   // Next pin values for the current digit; gap cycle at cnt==0 keeps anodes off
   always_comb begin
      shadow_dp = shadow[39:32];
      nib       = shadow[{idx, 2'b00} +: 4];
      active    = (cnt != '0) && !dark[idx];
      an_next   = 8'hFF;
      seg_next  = 8'hFF;
      if (active) begin
         an_next  = ~(8'd1 << idx);
         seg_next = {~shadow_dp[idx], hex7(nib)};
      end
   end

   // Scan counters, load capture, frame-aligned shadow update and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         idx        <= '0;
         pend       <= '0;
         shadow     <= '0;
         an         <= 8'hFF;
         seg        <= 8'hFF;
         frame_done <= 1'b0;
      end else begin
         cnt <= dwell_end ? '0 : cnt + 1'b1;
         if (dwell_end) idx <= frame_end ? 3'd0 : idx + 3'd1;
         if (load) pend <= {dp, data};
         // A load on the boundary edge goes straight to shadow so it is not lost for a frame
         if (frame_end) shadow <= load ? {dp, data} : pend;
         an         <= an_next;
         seg        <= seg_next;
         frame_done <= frame_end;
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with DIV=4, NUM_DIGITS=8 (32-cycle frame).
// t counts rising edges since reset release; outputs sampled 1ns after each edge.
module tb_seg7_scan;

   logic        clk;
   logic        rst_n;
   logic        load;
   logic [31:0] data;
   logic [7:0]  dp;
   logic [7:0]  blank;
   logic [7:0]  an;
   logic [7:0]  seg;
   logic        frame_done;

   int unsigned nvec;
   int unsigned nerr;
   int unsigned t;

   typedef struct {
      int unsigned ncyc;
      logic [7:0]  blank;
      logic [7:0]  an;
      logic [7:0]  seg;
      logic        fd;
   } vec_t;

   vec_t tbl [0:12];

   seg7_scan #(.DIV(4), .NUM_DIGITS(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .data       (data),
      .dp         (dp),
      .blank      (blank),
      .an         (an),
      .seg        (seg),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic goto(input int unsigned target);
      while (t < target) tick();
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s (t=%0d): got %h expected %h", name, t, got, exp);
      end
   endtask

   task automatic chk3(input string name, input logic [7:0] ea, input logic [7:0] es, input logic ef);
      chk({name, " an"}, an, ea);
      chk({name, " seg"}, seg, es);
      chk({name, " fd"}, {7'd0, frame_done}, {7'd0, ef});
   endtask

   task automatic do_load(input logic [31:0] d, input logic [7:0] p);
      load = 1'b1;
      data = d;
      dp   = p;
      tick();
      load = 1'b0;
   endtask

   initial begin
      nvec  = 0;
      nerr  = 0;
      t     = 0;
      rst_n = 1'b0;
      load  = 1'b0;
      data  = '0;
      dp    = '0;
      blank = '0;

      // ncyc, blank, an, seg, frame_done  (cumulative t: 1,2,4,5,6,32,33,34,35,47,50,51,54)
      tbl[0]  = '{1,  8'h00, 8'hFF, 8'hFF, 1'b0};
      tbl[1]  = '{1,  8'h00, 8'hFE, 8'hC0, 1'b0};
      tbl[2]  = '{2,  8'h00, 8'hFE, 8'hC0, 1'b0};
      tbl[3]  = '{1,  8'h00, 8'hFF, 8'hFF, 1'b0};
      tbl[4]  = '{1,  8'h00, 8'hFD, 8'hC0, 1'b0};
      tbl[5]  = '{26, 8'h00, 8'h7F, 8'hC0, 1'b1};
      tbl[6]  = '{1,  8'h00, 8'hFF, 8'hFF, 1'b0};
      tbl[7]  = '{1,  8'h00, 8'hFE, 8'hC0, 1'b0};
      tbl[8]  = '{1,  8'h0F, 8'hFF, 8'hFF, 1'b0};
      tbl[9]  = '{12, 8'h0F, 8'hFF, 8'hFF, 1'b0};
      tbl[10] = '{3,  8'h0F, 8'hEF, 8'hC0, 1'b0};
      tbl[11] = '{1,  8'h10, 8'hFF, 8'hFF, 1'b0};
      tbl[12] = '{3,  8'h00, 8'hDF, 8'hC0, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      chk3("reset", 8'hFF, 8'hFF, 1'b0);
      rst_n = 1'b1;
      t = 0;

      for (int i = 0; i < 13; i++) begin
         blank = tbl[i].blank;
         repeat (tbl[i].ncyc) tick();
         chk3($sformatf("vec%0d", i), tbl[i].an, tbl[i].seg, tbl[i].fd);
      end

      // Mid-frame load: held until the next frame
      goto(59);
      do_load(32'h89ABCDEF, 8'h01);
      goto(62); chk3("midload old d7", 8'h7F, 8'hC0, 1'b0);
      goto(64); chk3("midload boundary", 8'h7F, 8'hC0, 1'b1);
      goto(65); chk3("midload gap", 8'hFF, 8'hFF, 1'b0);
      goto(66); chk3("midload d0", 8'hFE, 8'h0E, 1'b0);
      goto(70); chk3("midload d1", 8'hFD, 8'h86, 1'b0);
      goto(94); chk3("midload d7", 8'h7F, 8'h80, 1'b0);

      // Load on the frame-boundary edge bypasses pend
      goto(127);
      do_load(32'h12345678, 8'h00);
      goto(130); chk3("bypass d0", 8'hFE, 8'h80, 1'b0);
      goto(134); chk3("bypass d1", 8'hFD, 8'hF8, 1'b0);

      // Back-to-back loads: last one wins
      goto(139);
      load = 1'b1;
      data = 32'h11111111;
      dp   = 8'h00;
      tick();
      data = 32'h22222222;
      tick();
      load = 1'b0;
      goto(158); chk3("b2b old d7", 8'h7F, 8'hF9, 1'b0);
      goto(162); chk3("b2b d0", 8'hFE, 8'hA4, 1'b0);
      goto(190); chk3("b2b d7", 8'h7F, 8'hA4, 1'b0);

      // Value with leading zeros
      goto(199);
      do_load(32'h000000A5, 8'h00);
      goto(226); chk3("lz d0", 8'hFE, 8'h92, 1'b0);
      goto(230); chk3("lz d1", 8'hFD, 8'h88, 1'b0);
`ifdef SEG7_LZ_BLANK_EN
      goto(234); chk3("lz d2", 8'hFF, 8'hFF, 1'b0);
      goto(254); chk3("lz d7", 8'hFF, 8'hFF, 1'b0);
`else
      goto(234); chk3("lz d2", 8'hFB, 8'hC0, 1'b0);
      goto(254); chk3("lz d7", 8'h7F, 8'hC0, 1'b0);
`endif

      // Reset during digit 5 dwell, with a load pending in pend
      goto(278);
      do_load(32'h33333333, 8'h00);
`ifdef SEG7_LZ_BLANK_EN
      chk3("pre-reset d5", 8'hFF, 8'hFF, 1'b0);
`else
      chk3("pre-reset d5", 8'hDF, 8'hC0, 1'b0);
`endif
      #2;
      rst_n = 1'b0;
      #1;
      chk3("async reset", 8'hFF, 8'hFF, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk3("held reset", 8'hFF, 8'hFF, 1'b0);
      rst_n = 1'b1;
      t = 0;
      goto(1); chk3("restart gap", 8'hFF, 8'hFF, 1'b0);
      goto(2); chk3("restart d0", 8'hFE, 8'hC0, 1'b0);
`ifdef SEG7_LZ_BLANK_EN
      goto(6); chk3("restart d1", 8'hFF, 8'hFF, 1'b0);
`else
      goto(6); chk3("restart d1", 8'hFD, 8'hC0, 1'b0);
`endif
      goto(34); chk3("lost load d0", 8'hFE, 8'hC0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
